// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS pipeline front end.
//   XLEN / JIDX_W       : datapath width and J-format jump index width
//   DEFAULT_RESET_PC    : PC loaded on reset
//   DEFAULT_NOP_INSTR   : bubble instruction (sll $0,$0,0)
//   pc_sel_e            : next-PC source select
//   word_align()        : clears the two byte-offset bits of an address
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam int XLEN   = 32;
    localparam int JIDX_W = 26;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } pc_sel_e;

    // Instruction addresses are always word aligned; masking keeps every
    // input bit referenced so no bit is left dangling.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with squash, load and hold behaviour.
//   clk          : rising-edge clock
//   rst_n        : synchronous active-low reset
//   i_squash     : load the bubble (NOP, valid=0) but still capture PC+4
//   i_load       : capture a fetched instruction (valid=1)
//   i_instr      : fetched instruction word
//   i_pc_plus4   : PC+4 of the fetched instruction
//   o_instr      : registered instruction
//   o_pc_plus4   : registered PC+4
//   o_valid      : register holds a real instruction
// With neither i_squash nor i_load the contents hold (stall).
// -----------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_squash,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);

    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_plus4;
    logic            r_valid;

    // Squash wins over load; the caller keeps i_load low during a squash anyway.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (i_squash) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/if_stage_pc_unit.sv
// -----------------------------------------------------------------------------
// if_stage_pc_unit
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register
// and a counter of valid instructions loaded into IF/ID.
//   clk             : rising-edge clock
//   rst_n           : synchronous active-low reset (highest priority)
//   imem_instr      : instruction word read combinationally at imem_addr
//   stall           : hold PC, IF/ID and fetch_count; redirects ignored
//   flush           : squash IF/ID (overrides stall)
//   jump_en         : j/jal taken in ID (beats branch_en)
//   jump_target28   : instr_index << 2 from ID
//   branch_en       : branch taken in ID
//   branch_target   : absolute branch target from ID
//   imem_addr       : current PC
//   if_id_instr     : IF/ID instruction
//   if_id_pc_plus4  : IF/ID PC+4
//   if_id_valid     : IF/ID holds a real instruction
//   fetch_count     : number of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module if_stage_pc_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   imem_instr,
    input  logic              stall,
    input  logic              flush,
    input  logic              jump_en,
    input  logic [JIDX_W+1:0] jump_target28,
    input  logic              branch_en,
    input  logic [XLEN-1:0]   branch_target,
    output logic [XLEN-1:0]   imem_addr,
    output logic [XLEN-1:0]   if_id_instr,
    output logic [XLEN-1:0]   if_id_pc_plus4,
    output logic              if_id_valid,
    output logic [XLEN-1:0]   fetch_count
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_fetch_count;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_jump_target;
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_if_id_pc_plus4;
    pc_sel_e         w_pc_sel;
    logic            w_redirect;
    logic            w_squash;
    logic            w_load;

    // Natural 32-bit wrap: 0xFFFF_FFFC + 4 = 0.
    assign w_pc_plus4 = r_pc + 32'd4;

    // The jump sitting in IF/ID supplies the segment bits of its own PC+4.
    assign w_jump_target   = word_align({w_if_id_pc_plus4[XLEN-1:JIDX_W+2], jump_target28});
    assign w_branch_target = word_align(branch_target);

    // A stalled ID stage has not really resolved its control flow yet.
    assign w_redirect = (jump_en | branch_en) & ~stall;
    assign w_squash   = flush | w_redirect;
    assign w_load     = ~stall & ~w_squash;

    always_comb begin
        w_pc_sel = SEL_SEQ;
        if (jump_en) begin
            w_pc_sel = SEL_JMP;
        end else if (branch_en) begin
            w_pc_sel = SEL_BR;
        end
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (w_pc_sel)
            SEL_JMP: w_pc_next = w_jump_target;
            SEL_BR:  w_pc_next = w_branch_target;
            default: w_pc_next = w_pc_plus4;
        endcase
    end

    // A flush alone does not stop the PC; only stall freezes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (!stall) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= '0;
        end else if (w_load) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_squash   (w_squash),
        .i_load     (w_load),
        .i_instr    (imem_instr),
        .i_pc_plus4 (w_pc_plus4),
        .o_instr    (if_id_instr),
        .o_pc_plus4 (w_if_id_pc_plus4),
        .o_valid    (if_id_valid)
    );

    assign imem_addr      = r_pc;
    assign if_id_pc_plus4 = w_if_id_pc_plus4;
    assign fetch_count    = r_fetch_count;

endmodule
